// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
//   Load/store front end for the byte-addressable data RAM. Takes one RISC-V
//   load/store from execute, issues a single RAM request (word lane data
//   replicated, byte mask), aligns/extends load data, and hands the result to
//   writeback. One transaction in flight at a time.
// Ports
//   clk, rstf                 clock, async active-low reset
//   t_req_*                   execute request (valid/ready, we, funct3, addr, data, rd)
//   i_mem_*                   RAM request (valid/ready, we, byte addr, data, mask)
//   t_mem_valid/ready/data    RAM read return (pulse, no backpressure)
//   i_wb_*                    writeback result (valid/ready, data, rd, err)
module lsu_mem_initiator #(
  parameter int DEPTH = 8192,
  parameter int AW    = 32,
  localparam int MAW  = $clog2(DEPTH) + 2
) (
  input  logic           clk,
  input  logic           rstf,
  input  logic           t_req_valid,
  output logic           t_req_ready,
  input  logic           t_req_we,
  input  logic [2:0]     t_req_funct3,
  input  logic [AW-1:0]  t_req_addr,
  input  logic [31:0]    t_req_data,
  input  logic [4:0]     t_req_rd,
  output logic           i_mem_valid,
  input  logic           i_mem_ready,
  output logic           i_mem_we,
  output logic [MAW-1:0] i_mem_addr,
  output logic [31:0]    i_mem_data,
  output logic [3:0]     i_mem_mask,
  input  logic           t_mem_valid,
  output logic           t_mem_ready,
  input  logic [31:0]    t_mem_data,
  output logic           i_wb_valid,
  input  logic           i_wb_ready,
  output logic [31:0]    i_wb_data,
  output logic [4:0]     i_wb_rd,
  output logic [1:0]     i_wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic        ready_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        f3_ok, misal, oor;
  logic [1:0]  err_in;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [31:0] ld_sh, ld_ext;

  assign accept      = t_req_valid & t_req_ready;
  assign t_req_ready = ready_q;
  assign i_mem_valid = (state == REQ);
  assign t_mem_ready = (state == WAIT);
  assign i_wb_valid  = (state == RESP);

  // Request checks, evaluated on the incoming request
  always_comb begin
    f3_ok = 1'b0;
    case (t_req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~t_req_we;   // unsigned forms are load-only
      default:                f3_ok = 1'b0;
    endcase
    misal  = ((t_req_funct3[1:0] == 2'b01) & t_req_addr[0]) |
             ((t_req_funct3[1:0] == 2'b10) & (t_req_addr[1:0] != 2'b00));
    oor    = (t_req_addr >> MAW) != '0;
    err_in = !f3_ok ? 2'd3 : misal ? 2'd1 : oor ? 2'd2 : 2'd0;
  end

  // Store lane replication and byte mask
  always_comb begin
    st_data = t_req_data;
    st_mask = 4'b1111;
    case (t_req_funct3[1:0])
      2'b00: begin
        st_data = {4{t_req_data[7:0]}};
        st_mask = 4'b0001 << t_req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{t_req_data[15:0]}};
        st_mask = 4'b0011 << t_req_addr[1:0];
      end
      default: ;
    endcase
  end

  // Load align and extend
  always_comb begin
    ld_sh  = t_mem_data >> {off_q, 3'b000};
    ld_ext = ld_sh;
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rstf)
    if (!rstf) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept)      state_n = (err_in != 2'd0) ? RESP : REQ;
      REQ:  if (i_mem_ready) state_n = i_mem_we ? RESP : WAIT;
      WAIT: if (t_mem_valid) state_n = RESP;
      RESP: if (i_wb_ready)  state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      ready_q    <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      i_mem_we   <= 1'b0;
      i_mem_addr <= '0;
      i_mem_data <= '0;
      i_mem_mask <= '0;
      i_wb_data  <= '0;
      i_wb_rd    <= '0;
      i_wb_err   <= '0;
    end else begin
      // Registered so ready stays low in reset and in the RESP handshake cycle
      ready_q <= (state_n == IDLE);
      if (accept) begin
        f3_q      <= t_req_funct3;
        off_q     <= t_req_addr[1:0];
        rd_q      <= t_req_rd;
        i_wb_err  <= err_in;
        i_wb_data <= '0;
        i_wb_rd   <= '0;
        if (err_in == 2'd0) begin
          i_mem_we   <= t_req_we;
          i_mem_addr <= t_req_addr[MAW-1:0];
          i_mem_data <= t_req_we ? st_data : 32'd0;
          i_mem_mask <= t_req_we ? st_mask : 4'b0000;
        end
      end
      if (state == WAIT && t_mem_valid) begin
        i_wb_data <= ld_ext;
        i_wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;
  localparam int MAW = 15;

  logic           clk = 1'b0;
  logic           rstf;
  logic           t_req_valid, t_req_ready, t_req_we;
  logic [2:0]     t_req_funct3;
  logic [31:0]    t_req_addr, t_req_data;
  logic [4:0]     t_req_rd;
  logic           i_mem_valid, i_mem_ready, i_mem_we;
  logic [MAW-1:0] i_mem_addr;
  logic [31:0]    i_mem_data;
  logic [3:0]     i_mem_mask;
  logic           t_mem_valid, t_mem_ready;
  logic [31:0]    t_mem_data;
  logic           i_wb_valid, i_wb_ready;
  logic [31:0]    i_wb_data;
  logic [4:0]     i_wb_rd;
  logic [1:0]     i_wb_err;

  // RAM model / manual response controls
  logic        auto_ram, ram_v, man_v;
  logic [31:0] ram_d, man_d;
  bit   [31:0] ram [64];
  int          mem_cnt = 0;
  int          ncmp = 0, nerr = 0;

  assign t_mem_valid = ram_v | man_v;
  assign t_mem_data  = man_v ? man_d : ram_d;

  lsu_mem_initiator #(.DEPTH(8192), .AW(32)) dut (
    .clk(clk), .rstf(rstf),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_we(t_req_we),
    .t_req_funct3(t_req_funct3), .t_req_addr(t_req_addr), .t_req_data(t_req_data),
    .t_req_rd(t_req_rd),
    .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready), .i_mem_we(i_mem_we),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data), .i_mem_mask(i_mem_mask),
    .t_mem_valid(t_mem_valid), .t_mem_ready(t_mem_ready), .t_mem_data(t_mem_data),
    .i_wb_valid(i_wb_valid), .i_wb_ready(i_wb_ready), .i_wb_data(i_wb_data),
    .i_wb_rd(i_wb_rd), .i_wb_err(i_wb_err)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: writes apply on handshake, reads return the next cycle
  always @(posedge clk) begin
    logic        hs, we;
    logic [5:0]  wi;
    logic [31:0] wd;
    logic [3:0]  wm;
    hs = i_mem_valid && i_mem_ready;
    we = i_mem_we;
    wi = i_mem_addr[7:2];
    wd = i_mem_data;
    wm = i_mem_mask;
    if (i_mem_valid) mem_cnt++;
    #1;
    ram_v = 1'b0;
    if (hs) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (wm[b]) ram[wi][8*b +: 8] = wd[8*b +: 8];
      end else if (auto_ram && rstf) begin
        ram_v = 1'b1;
        ram_d = ram[wi];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req_ready"}, 32'(t_req_ready), 0);
    chk({tag, ".mem_valid"}, 32'(i_mem_valid), 0);
    chk({tag, ".mem_we"},    32'(i_mem_we), 0);
    chk({tag, ".mem_addr"},  32'(i_mem_addr), 0);
    chk({tag, ".mem_data"},  i_mem_data, 0);
    chk({tag, ".mem_mask"},  32'(i_mem_mask), 0);
    chk({tag, ".mem_ready"}, 32'(t_mem_ready), 0);
    chk({tag, ".wb_valid"},  32'(i_wb_valid), 0);
    chk({tag, ".wb_data"},   i_wb_data, 0);
    chk({tag, ".wb_rd"},     32'(i_wb_rd), 0);
    chk({tag, ".wb_err"},    32'(i_wb_err), 0);
  endtask

  // Present one request at a negedge once ready; returns just after accept edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    int k = 0;
    @(negedge clk);
    while (!t_req_ready && k < 20) begin @(negedge clk); k++; end
    chk("req_ready", 32'(t_req_ready), 1);
    t_req_valid = 1'b1; t_req_we = we; t_req_funct3 = f3;
    t_req_addr = a; t_req_data = d; t_req_rd = rd;
    @(posedge clk);
    #1 t_req_valid = 1'b0;
  endtask

  // Count negedges after accept until wb valid; lat0 = negedges already consumed
  task automatic wait_wb(input string tag, input int lat0, input int exp_lat,
                         input logic [31:0] ed, input logic [31:0] erd, input logic [31:0] eerr);
    int lat = lat0;
    while (!(lat > 0 && i_wb_valid) && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, ".lat"},  32'(lat), 32'(exp_lat));
    chk({tag, ".data"}, i_wb_data, ed);
    chk({tag, ".rd"},   32'(i_wb_rd), erd);
    chk({tag, ".err"},  32'(i_wb_err), eerr);
  endtask

  initial begin
    int c;
    int k;
    rstf = 1'b0; t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = '0;
    t_req_addr = '0; t_req_data = '0; t_req_rd = '0;
    i_mem_ready = 1'b1; i_wb_ready = 1'b1;
    auto_ram = 1'b1; ram_v = 1'b0; ram_d = '0; man_v = 1'b0; man_d = '0;
    #12;
    chk_zero("reset");
    @(negedge clk) rstf = 1'b1;

    // SW 0x10
    issue(1'b1, 3'b010, 32'h10, 32'h8899AABB, 5'd7);
    @(negedge clk);
    chk("sw.mem_valid", 32'(i_mem_valid), 1);
    chk("sw.mem_addr",  32'(i_mem_addr), 32'h10);
    chk("sw.mem_mask",  32'(i_mem_mask), 32'hF);
    chk("sw.mem_data",  i_mem_data, 32'h8899AABB);
    chk("sw.mem_we",    32'(i_mem_we), 1);
    wait_wb("sw", 1, 2, 0, 0, 0);

    issue(1'b0, 3'b000, 32'h13, 0, 5'd3);
    wait_wb("lb13", 0, 3, 32'hFFFFFF88, 3, 0);
    issue(1'b0, 3'b101, 32'h12, 0, 5'd4);
    wait_wb("lhu12", 0, 3, 32'h00008899, 4, 0);

    // SB 0x11
    issue(1'b1, 3'b000, 32'h11, 32'h000000CC, 5'd1);
    @(negedge clk);
    chk("sb.mem_data", i_mem_data, 32'hCCCCCCCC);
    chk("sb.mem_mask", 32'(i_mem_mask), 32'h2);
    wait_wb("sb", 1, 2, 0, 0, 0);
    issue(1'b0, 3'b010, 32'h10, 0, 5'd5);
    wait_wb("lw10", 0, 3, 32'h8899CCBB, 5, 0);

    // Error paths: no RAM traffic
    c = mem_cnt;
    issue(1'b0, 3'b010, 32'h12, 0, 5'd2);
    wait_wb("lw_mis", 0, 1, 0, 0, 1);
    issue(1'b0, 3'b001, 32'h11, 0, 5'd2);
    wait_wb("lh_mis", 0, 1, 0, 0, 1);
    issue(1'b0, 3'b011, 32'h10, 0, 5'd2);
    wait_wb("f3_011", 0, 1, 0, 0, 3);
    issue(1'b0, 3'b010, 32'h0001_0000, 0, 5'd2);
    wait_wb("oor", 0, 1, 0, 0, 2);
    issue(1'b1, 3'b100, 32'h10, 32'h55, 5'd2);
    wait_wb("st_f3u", 0, 1, 0, 0, 3);
    issue(1'b0, 3'b010, 32'h13, 0, 5'd2);   // misaligned beats illegal range/lanes
    wait_wb("lw_mis3", 0, 1, 0, 0, 1);
    @(negedge clk);
    chk("err.no_mem", 32'(mem_cnt), 32'(c));

    issue(1'b0, 3'b100, 32'h10, 0, 5'd10);
    wait_wb("lbu10", 0, 3, 32'h000000BB, 10, 0);
    issue(1'b0, 3'b001, 32'h10, 0, 5'd11);
    wait_wb("lh10", 0, 3, 32'hFFFFCCBB, 11, 0);

    // Stalls: RAM not ready 3 cycles, writeback not ready 4 cycles
    i_mem_ready = 1'b0;
    issue(1'b1, 3'b001, 32'h16, 32'h00001234, 5'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall.mem_valid", 32'(i_mem_valid), 1);
      chk("stall.mem_addr",  32'(i_mem_addr), 32'h16);
      chk("stall.mem_data",  i_mem_data, 32'h12341234);
      chk("stall.mem_mask",  32'(i_mem_mask), 32'hC);
      chk("stall.mem_we",    32'(i_mem_we), 1);
      chk("stall.req_ready", 32'(t_req_ready), 0);
    end
    i_mem_ready = 1'b1; i_wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall.wb_valid",  32'(i_wb_valid), 1);
      chk("stall.wb_data",   i_wb_data, 0);
      chk("stall.wb_rd",     32'(i_wb_rd), 0);
      chk("stall.wb_err",    32'(i_wb_err), 0);
      chk("stall.mem_valid2", 32'(i_mem_valid), 0);
      chk("stall.req_ready2", 32'(t_req_ready), 0);
    end
    i_wb_ready = 1'b1;
    @(negedge clk);
    chk("stall.wb_done", 32'(i_wb_valid), 0);
    chk("stall.ready_back", 32'(t_req_ready), 1);
    issue(1'b0, 3'b001, 32'h16, 0, 5'd12);
    wait_wb("lh16", 0, 3, 32'h00001234, 12, 0);

    // Reset during WAIT, late RAM data must be ignored
    auto_ram = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 0, 5'd6);
    k = 0;
    while (!t_mem_ready && k < 10) begin @(negedge clk); k++; end
    chk("rst.in_wait", 32'(t_mem_ready), 1);
    rstf = 1'b0;
    #1;
    chk_zero("rst_wait");
    @(negedge clk);
    rstf = 1'b1; man_v = 1'b1; man_d = 32'hDEADBEEF;
    @(negedge clk);
    man_v = 1'b0;
    chk("rst.idle_ready", 32'(t_req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.no_wb", 32'(i_wb_valid), 0);
    end
    auto_ram = 1'b1;
    issue(1'b0, 3'b010, 32'h10, 0, 5'd8);
    wait_wb("lw_post_rst", 0, 3, 32'h8899CCBB, 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
